// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: STEP bits per clock, LSB first, through a registered carry.
// Optional signed-overflow output enabled by defining SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSTEP = WIDTH / STEP;
    localparam int unsigned CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if (WIDTH == 0 || STEP == 0) begin : g_bad_size
        $error("serial_add_sub: WIDTH and STEP must be >= 1");
    end else if (WIDTH % STEP != 0) begin : g_bad_step
        $error("serial_add_sub: WIDTH must be a multiple of STEP");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [STEP-1:0]  sum_c;
    logic [STEP:0]    chain_c;
    logic [WIDTH-1:0] res_next_c;

    // STEP chained full adders on the low bits of the operand shift registers
    always_comb begin
        sum_c      = '0;
        chain_c    = '0;
        chain_c[0] = carry;
        for (int i = 0; i < int'(STEP); i++) begin
            sum_c[i]       = opa[i] ^ opb[i] ^ chain_c[i];
            chain_c[i+1]   = (opa[i] & opb[i]) | (chain_c[i] & (opa[i] ^ opb[i]));
        end
        res_next_c = (res >> STEP) | (WIDTH'(sum_c) << (WIDTH - STEP));
    end

    // Control and datapath registers; sum bits enter the result from the MSB side
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> STEP;
                    opb   <= opb >> STEP;
                    carry <= chain_c[STEP];
                    res   <= res_next_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NSTEP - 1)) begin
                        s     <= res_next_c;
                        cout  <= chain_c[STEP];
`ifdef SERIAL_ADD_SUB_OVF_EN
                        ovf   <= chain_c[STEP-1] ^ chain_c[STEP];
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub: an 8-bit STEP=1 instance and an 8-bit STEP=4 instance.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       start4;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       busy, busy4;
    logic       done, done4;
    logic [7:0] s, s4;
    logic       cout, cout4;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic       ovf, ovf4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .STEP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .s(s), .cout(cout)
`ifdef SERIAL_ADD_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_add_sub #(.WIDTH(8), .STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4)
`ifdef SERIAL_ADD_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    // Pulse start on one instance, scramble the inputs afterwards, count cycles until done
    task automatic do_op(input bit w4, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ic, input logic is, output int lat);
        a = ia; b = ib; cin = ic; sub = is;
        if (w4) start4 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start4 = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (((w4 ? done4 : done) !== 1'b1) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start4 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({busy, done, s, cout} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b s=%h cout=%b, want 0/0/00/0", busy, done, s, cout);
        end
        n_checks++;
        if ({busy4, done4, s4, cout4} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_state4: got busy=%b done=%b s=%h cout=%b, want 0/0/00/0", busy4, done4, s4, cout4);
        end
`ifdef SERIAL_ADD_SUB_OVF_EN
        n_checks++;
        if ({ovf, ovf4} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b%b want 00", ovf, ovf4);
        end
`endif
    endtask

    task automatic test_add();
        int lat;
        int busy_cycles = 0;
        a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (busy === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            @(posedge clk); #1;
        end
        lat = busy_cycles;
        n_checks++;
        if (lat != 8 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL add_busy_latency: got busy %0d cycles done=%b, want 8 cycles done=1", lat, done);
        end
        n_checks++;
        if ({s, cout} !== {8'h96, 1'b0}) begin
            n_fail++;
            $display("FAIL add_5a_3c: got s=%h cout=%b want s=96 cout=0", s, cout);
        end
`ifdef SERIAL_ADD_SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL add_5a_3c_ovf: got %b want 1", ovf);
        end
`endif
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || s !== 8'h96) begin
            n_fail++;
            $display("FAIL done_pulse_hold: got done=%b s=%h want done=0 s=96", done, s);
        end

        do_op(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, lat);
        n_checks++;
        if (lat != 8 || {s, cout} !== {8'h01, 1'b1}) begin
            n_fail++;
            $display("FAIL add_ff_01_c: got lat=%0d s=%h cout=%b want lat=8 s=01 cout=1", lat, s, cout);
        end
`ifdef SERIAL_ADD_SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ff_01_ovf: got %b want 0", ovf);
        end
`endif
    endtask

    task automatic test_sub();
        int lat;
        do_op(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, lat);
        n_checks++;
        if (lat != 8 || {s, cout} !== {8'hF0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_10_20: got lat=%0d s=%h cout=%b want lat=8 s=f0 cout=0", lat, s, cout);
        end
`ifdef SERIAL_ADD_SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_10_20_ovf: got %b want 0", ovf);
        end
`endif
        do_op(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, lat);
        n_checks++;
        if ({s, cout} !== {8'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_80_01: got s=%h cout=%b want s=7f cout=1", s, cout);
        end
`ifdef SERIAL_ADD_SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_80_01_ovf: got %b want 1", ovf);
        end
`endif
        do_op(1'b0, 8'h05, 8'h03, 1'b1, 1'b1, lat);
        n_checks++;
        if ({s, cout} !== {8'h01, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_borrow_in: got s=%h cout=%b want s=01 cout=1", s, cout);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'h00; b = 8'h00; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != 8 || s !== 8'h96) begin
            n_fail++;
            $display("FAIL start_ignored: got lat=%0d s=%h want lat=8 s=96", lat, s);
        end
        a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != 8 || s !== 8'h02) begin
            n_fail++;
            $display("FAIL b2b_result: got lat=%0d s=%h want lat=8 s=02", lat, s);
        end
    endtask

    task automatic test_abort();
        int seen = 0;
        a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({busy, done, s} !== 10'h000) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b s=%h want 0/0/00", busy, done, s);
        end
        repeat (10) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0 || s !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses s=%h want 0 pulses s=00", seen, s);
        end
    endtask

    task automatic test_step4();
        int lat;
        do_op(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat != 2 || {s4, cout4} !== {8'h96, 1'b0}) begin
            n_fail++;
            $display("FAIL step4_add: got lat=%0d s=%h cout=%b want lat=2 s=96 cout=0", lat, s4, cout4);
        end
`ifdef SERIAL_ADD_SUB_OVF_EN
        n_checks++;
        if (ovf4 !== 1'b1) begin
            n_fail++;
            $display("FAIL step4_add_ovf: got %b want 1", ovf4);
        end
`endif
        do_op(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, lat);
        n_checks++;
        if (lat != 2 || {s4, cout4} !== {8'h01, 1'b1}) begin
            n_fail++;
            $display("FAIL step4_carry: got lat=%0d s=%h cout=%b want lat=2 s=01 cout=1", lat, s4, cout4);
        end
        do_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, lat);
        n_checks++;
        if (lat != 2 || {s4, cout4} !== {8'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL step4_sub: got lat=%0d s=%h cout=%b want lat=2 s=7f cout=1", lat, s4, cout4);
        end
`ifdef SERIAL_ADD_SUB_OVF_EN
        n_checks++;
        if (ovf4 !== 1'b1) begin
            n_fail++;
            $display("FAIL step4_sub_ovf: got %b want 1", ovf4);
        end
`endif
        do_op(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, lat);
        n_checks++;
        if ({s4, cout4} !== {8'hF0, 1'b0}) begin
            n_fail++;
            $display("FAIL step4_borrow: got s=%h cout=%b want s=f0 cout=0", s4, cout4);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_abort();
        test_step4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
